// File: rtl/metaframe_sync.sv
// Metaframe alignment for a 64B/67B lane: hunts for the sync word, verifies its
// period over several metaframes, and forwards payload words once locked.
module metaframe_sync #(
  parameter int METAFRAME_LEN = 2048,
  parameter int LOCK_CNT      = 4,
  parameter int LOSS_CNT      = 4
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [63:0] DATA_IN,
  input  logic [1:0]  HEADER_IN,
  input  logic        DATA_IN_VALID,
  input  logic        LOCKED_IN,
  output logic [63:0] DATA_OUT,
  output logic        CTRL_OUT,
  output logic        DATA_OUT_VALID,
  output logic        FRAME_LOCKED,
  output logic        METAFRAME_START,
  output logic [57:0] SCRAM_STATE,
  output logic [1:0]  DIAG_STATUS,
  output logic        HDR_ERR,
  output logic [7:0]  SYNC_ERR_CNT
);

  localparam logic [63:0] SYNC_WORD = 64'h78F6_78F6_78F6_78F6;
  localparam logic [63:0] SKIP_WORD = 64'h1E1E_1E1E_1E1E_1E1E;
  localparam logic [5:0]  SCRAM_TAG = 6'b001010;
  localparam logic [5:0]  DIAG_TAG  = 6'b011001;
  localparam logic [15:0] LAST_POS  = 16'(METAFRAME_LEN - 1);
  localparam logic [15:0] LOCK_TGT  = 16'(LOCK_CNT);
  localparam logic [15:0] LOSS_TGT  = 16'(LOSS_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] word_ctr_r, word_ctr_nxt_s;
  logic [15:0] good_r, good_nxt_s;
  logic [15:0] bad_r, bad_nxt_s;
  logic [7:0]  err_r, err_nxt_s;
  logic        start_nxt_s, dov_nxt_s, hdr_err_nxt_s;

  logic        is_ctrl_s, hdr_bad_s, is_sync_s, is_skip_s, is_scram_s, is_diag_s;
  logic        framing_s, on_pos_s;

  logic [63:0] dout_r;
  logic        ctrl_r, dov_r, locked_r, start_r, hdr_err_r;
  logic [57:0] scram_r;
  logic [1:0]  diag_r;

  // Framing words are only recognised behind a control header.
  assign is_ctrl_s  = (HEADER_IN == 2'b10);
  assign hdr_bad_s  = (HEADER_IN == 2'b00) || (HEADER_IN == 2'b11);
  assign is_sync_s  = is_ctrl_s && (DATA_IN == SYNC_WORD);
  assign is_skip_s  = is_ctrl_s && (DATA_IN == SKIP_WORD);
  assign is_scram_s = is_ctrl_s && (DATA_IN[63:58] == SCRAM_TAG);
  assign is_diag_s  = is_ctrl_s && (DATA_IN[63:58] == DIAG_TAG);
  assign framing_s  = is_sync_s || is_skip_s || is_scram_s || is_diag_s;
  assign on_pos_s   = (word_ctr_r == LAST_POS);

  // Framing state and position counters.
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      state_r    <= ST_HUNT;
      word_ctr_r <= 16'd0;
      good_r     <= 16'd0;
      bad_r      <= 16'd0;
      err_r      <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      word_ctr_r <= word_ctr_nxt_s;
      good_r     <= good_nxt_s;
      bad_r      <= bad_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  // Next-state, counter and pulse decisions for the current input word.
  always_comb begin
    state_nxt_s    = state_r;
    word_ctr_nxt_s = word_ctr_r;
    good_nxt_s     = good_r;
    bad_nxt_s      = bad_r;
    err_nxt_s      = err_r;
    start_nxt_s    = 1'b0;
    dov_nxt_s      = 1'b0;
    hdr_err_nxt_s  = 1'b0;
    if (!LOCKED_IN) begin
      state_nxt_s    = ST_HUNT;
      word_ctr_nxt_s = 16'd0;
      good_nxt_s     = 16'd0;
      bad_nxt_s      = 16'd0;
    end else if (DATA_IN_VALID) begin
      hdr_err_nxt_s  = hdr_bad_s;
      word_ctr_nxt_s = on_pos_s ? 16'd0 : word_ctr_r + 16'd1;
      case (state_r)
        ST_HUNT: begin
          // The entry sync word defines the phase: it sits at the last position.
          word_ctr_nxt_s = 16'd0;
          if (is_sync_s) begin
            state_nxt_s = ST_VERIFY;
            good_nxt_s  = 16'd1;
            bad_nxt_s   = 16'd0;
            start_nxt_s = 1'b1;
          end else begin
            good_nxt_s  = 16'd0;
          end
        end
        ST_VERIFY: begin
          if (on_pos_s && is_sync_s) begin
            good_nxt_s  = good_r + 16'd1;
            start_nxt_s = 1'b1;
            if ((good_r + 16'd1) == LOCK_TGT) begin
              state_nxt_s = ST_LOCKED;
              bad_nxt_s   = 16'd0;
            end else begin
              state_nxt_s = ST_VERIFY;
            end
          end else if (on_pos_s) begin
            state_nxt_s    = ST_HUNT;
            word_ctr_nxt_s = 16'd0;
            good_nxt_s     = 16'd0;
            bad_nxt_s      = 16'd0;
          end else begin
            state_nxt_s = ST_VERIFY;
          end
        end
        ST_LOCKED: begin
          dov_nxt_s = !framing_s && !hdr_bad_s;
          if (on_pos_s && is_sync_s) begin
            bad_nxt_s   = 16'd0;
            start_nxt_s = 1'b1;
          end else if (on_pos_s) begin
            bad_nxt_s = bad_r + 16'd1;
            err_nxt_s = (err_r == 8'hFF) ? err_r : err_r + 8'd1;
            if ((bad_r + 16'd1) == LOSS_TGT) begin
              state_nxt_s    = ST_HUNT;
              word_ctr_nxt_s = 16'd0;
              good_nxt_s     = 16'd0;
              bad_nxt_s      = 16'd0;
            end else begin
              state_nxt_s = ST_LOCKED;
            end
          end else begin
            bad_nxt_s = bad_r;
          end
        end
        default: begin
          state_nxt_s    = ST_HUNT;
          word_ctr_nxt_s = 16'd0;
          good_nxt_s     = 16'd0;
          bad_nxt_s      = 16'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Registered outputs; data and captured fields hold between qualifying words.
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      dout_r    <= 64'd0;
      ctrl_r    <= 1'b0;
      dov_r     <= 1'b0;
      locked_r  <= 1'b0;
      start_r   <= 1'b0;
      hdr_err_r <= 1'b0;
      scram_r   <= 58'd0;
      diag_r    <= 2'd0;
    end else begin
      dov_r     <= dov_nxt_s;
      start_r   <= start_nxt_s;
      hdr_err_r <= hdr_err_nxt_s;
      locked_r  <= (state_nxt_s == ST_LOCKED);
      if (dov_nxt_s) begin
        dout_r <= DATA_IN;
        ctrl_r <= is_ctrl_s;
      end
      if (DATA_IN_VALID && is_scram_s) begin
        scram_r <= DATA_IN[57:0];
      end
      if (DATA_IN_VALID && is_diag_s) begin
        diag_r <= DATA_IN[33:32];
      end
    end
  end

  assign DATA_OUT        = dout_r;
  assign CTRL_OUT        = ctrl_r;
  assign DATA_OUT_VALID  = dov_r;
  assign FRAME_LOCKED    = locked_r;
  assign METAFRAME_START = start_r;
  assign SCRAM_STATE     = scram_r;
  assign DIAG_STATUS     = diag_r;
  assign HDR_ERR         = hdr_err_r;
  assign SYNC_ERR_CNT    = err_r;

endmodule
